// File: rtl/stage4ma_pkg.sv
// Shared opcodes, flag bit positions and MA-stage state encoding.
package stage4ma_pkg;

    localparam logic [7:0] OPC_R_ADD = 8'h01;
    localparam logic [7:0] OPC_R_LD  = 8'h10;
    localparam logic [7:0] OPC_R_ST  = 8'h11;
    localparam logic [7:0] OPC_I_LDi = 8'h30;
    localparam logic [7:0] OPC_I_STi = 8'h31;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_BUSY = 1'b1
    } ma_state_t;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OPC_R_LD) || (op == OPC_I_LDi);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OPC_R_ST) || (op == OPC_I_STi);
    endfunction

endpackage

// File: rtl/stage4ma.sv
// Memory-access stage: LD/ST via a req/ack port, one-cycle pass-through otherwise.
// Define STAGE4MA_TIMEOUT_EN to abort a request after TIMEOUT BUSY cycles.
module stage4ma
    import stage4ma_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_in,
    input  logic [23:0]       pc_in,
    input  logic [23:0]       instr_in,
    input  logic [23:0]       result_in,
    input  logic [23:0]       store_data_in,
    input  logic [3:0]        tgt_gp_in,
    input  logic [3:0]        flags_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              enable_out,
    output logic [23:0]       pc_out,
    output logic [23:0]       instr_out,
    output logic [23:0]       result_out,
    output logic [3:0]        tgt_gp_out,
    output logic [3:0]        flags_out,
    output logic              bus_err_out
);

    ma_state_t         r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [23:0]       r_mem_wdata;

    logic [23:0]       r_pc;
    logic [23:0]       r_instr;
    logic [23:0]       r_res;
    logic [3:0]        r_tgt;
    logic [3:0]        r_flags;
    logic              r_is_ld;

    logic              r_en_out;
    logic [23:0]       r_pc_out;
    logic [23:0]       r_instr_out;
    logic [23:0]       r_res_out;
    logic [3:0]        r_tgt_out;
    logic [3:0]        r_flags_out;
    logic              r_bus_err;

    logic              w_busy;
    logic              w_ld;
    logic              w_st;
    logic              w_start;
    logic              w_pass;
    logic              w_ack;
    logic              w_to;
    logic              w_retire;
    logic [23:0]       w_ret_res;
    logic [23:0]       w_src_pc;
    logic [23:0]       w_src_instr;
    logic [3:0]        w_src_tgt;
    logic [3:0]        w_src_flags;

    assign w_busy  = (r_state == MA_BUSY);
    assign w_ld    = is_load(instr_in[23:16]);
    assign w_st    = is_store(instr_in[23:16]);
    assign w_start = ~w_busy & enable_in & (w_ld | w_st);
    assign w_pass  = ~w_busy & enable_in & ~(w_ld | w_st);
    assign w_ack   = w_busy & mem_ack;

`ifdef STAGE4MA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    assign w_to = w_busy & ~mem_ack
                & (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic w_unused_timeout;

    assign w_to             = 1'b0;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    assign w_retire = w_pass | w_ack | w_to;

    // Timeout retires in its last BUSY cycle, so EX may advance then too
    assign stall_out = ~rst
                     & (w_start | (w_busy & ~mem_ack & ~w_to));

    assign w_src_pc    = w_busy ? r_pc    : pc_in;
    assign w_src_instr = w_busy ? r_instr : instr_in;
    assign w_src_tgt   = w_busy ? r_tgt   : tgt_gp_in;
    assign w_src_flags = w_busy ? r_flags : flags_in;

    always_comb begin
        w_ret_res = r_res;
        unique case (1'b1)
            w_pass:            w_ret_res = result_in;
            w_to:              w_ret_res = '0;
            (w_ack & r_is_ld): w_ret_res = mem_rdata;
            default:           w_ret_res = r_res;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= MA_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pc        <= '0;
            r_instr     <= '0;
            r_res       <= '0;
            r_tgt       <= '0;
            r_flags     <= '0;
            r_is_ld     <= 1'b0;
            r_en_out    <= 1'b0;
            r_pc_out    <= '0;
            r_instr_out <= '0;
            r_res_out   <= '0;
            r_tgt_out   <= '0;
            r_flags_out <= '0;
            r_bus_err   <= 1'b0;
`ifdef STAGE4MA_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_en_out  <= w_retire;
            r_bus_err <= w_to;
            if (w_retire) begin
                r_pc_out    <= w_src_pc;
                r_instr_out <= w_src_instr;
                r_res_out   <= w_ret_res;
                r_tgt_out   <= w_src_tgt;
                r_flags_out <= w_src_flags;
            end
            case (r_state)
                MA_IDLE: begin
                    if (w_start) begin
                        r_state     <= MA_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_st;
                        r_mem_addr  <= result_in[ADDR_W-1:0];
                        r_mem_wdata <= store_data_in;
                        r_pc        <= pc_in;
                        r_instr     <= instr_in;
                        r_res       <= result_in;
                        r_tgt       <= tgt_gp_in;
                        r_flags     <= flags_in;
                        r_is_ld     <= w_ld;
`ifdef STAGE4MA_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                    end
                end
                MA_BUSY: begin
                    if (w_ack | w_to) begin
                        r_state   <= MA_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
`ifdef STAGE4MA_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign enable_out  = r_en_out;
    assign pc_out      = r_pc_out;
    assign instr_out   = r_instr_out;
    assign result_out  = r_res_out;
    assign tgt_gp_out  = r_tgt_out;
    assign flags_out   = r_flags_out;
    assign bus_err_out = r_bus_err;

endmodule

// File: tb/tb_stage4ma.sv
// Bench for stage4ma: vector table driven through an EX/memory model.
// Expected retirements go through a scoreboard queue.
module tb_stage4ma;
    import stage4ma_pkg::*;

    localparam int AW = 24;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_in;
    logic [23:0]   pc_in;
    logic [23:0]   instr_in;
    logic [23:0]   result_in;
    logic [23:0]   store_data_in;
    logic [3:0]    tgt_gp_in;
    logic [3:0]    flags_in;
    logic          stall_out;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic [23:0]   mem_rdata;
    logic          mem_ack;
    logic          enable_out;
    logic [23:0]   pc_out;
    logic [23:0]   instr_out;
    logic [23:0]   result_out;
    logic [3:0]    tgt_gp_out;
    logic [3:0]    flags_out;
    logic          bus_err_out;

    always #5 clk = ~clk;

    stage4ma #(
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_in    (enable_in),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .result_in    (result_in),
        .store_data_in(store_data_in),
        .tgt_gp_in    (tgt_gp_in),
        .flags_in     (flags_in),
        .stall_out    (stall_out),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .enable_out   (enable_out),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .result_out   (result_out),
        .tgt_gp_out   (tgt_gp_out),
        .flags_out    (flags_out),
        .bus_err_out  (bus_err_out)
    );

    typedef struct {
        logic [7:0]  opc;
        logic [23:0] pc;
        logic [23:0] res;
        logic [23:0] sd;
        logic [23:0] rdata;
        logic [3:0]  tgt;
        logic [3:0]  flg;
        int          delay;
        int          gap;
        logic [23:0] exp_res;
        logic        exp_err;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [23:0] pc;
        logic [23:0] instr;
        logic [23:0] res;
        logic [3:0]  tgt;
        logic [3:0]  flg;
        logic        err;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    exp_t last;
    vec_t cur;
    vec_t vecs[10];
    bit   cur_valid;
    bit   acc_last;
    int   stall_cnt;
    int   busy_cnt;
    int   bwait;

    function automatic vec_t mk(
        input logic [7:0]  opc,
        input logic [23:0] pc, res, sd, rdata,
        input logic [3:0]  tgt, flg,
        input int          delay, gap,
        input logic [23:0] exp_res,
        input logic        exp_err,
        input int          exp_stall
    );
        vec_t v;
        v.opc = opc; v.pc = pc; v.res = res; v.sd = sd;
        v.rdata = rdata; v.tgt = tgt; v.flg = flg;
        v.delay = delay; v.gap = gap; v.exp_res = exp_res;
        v.exp_err = exp_err; v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock: check retired outputs, model memory, drive EX, record acceptance
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (acc_last) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                last = sbq.pop_front();
            end
        end
        chk("enable_out", enable_out, acc_last);
        chk("pc_out", pc_out, last.pc);
        chk("instr_out", instr_out, last.instr);
        chk("result_out", result_out, last.res);
        chk("tgt_gp_out", tgt_gp_out, last.tgt);
        chk("flags_out", flags_out, last.flg);
        chk("bus_err_out", bus_err_out, acc_last & last.err);
        if (mem_req) begin
            chk("mem_req_ldst", cur_valid &
                (is_load(cur.opc) | is_store(cur.opc)), 1);
            chk("mem_addr", mem_addr, cur.res[AW-1:0]);
            chk("mem_we", mem_we, is_store(cur.opc));
            chk("mem_wdata", mem_wdata, cur.sd);
            mem_ack   = (bwait == cur.delay);
            mem_rdata = mem_ack ? cur.rdata : 24'($urandom);
            bwait++;
            busy_cnt++;
        end else begin
            bwait     = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 24'($urandom);
        end
        if (cur_valid) begin
            enable_in     = 1'b1;
            pc_in         = cur.pc;
            instr_in      = {cur.opc, cur.pc[15:0]};
            result_in     = cur.res;
            store_data_in = cur.sd;
            tgt_gp_in     = cur.tgt;
            flags_in      = cur.flg;
        end else begin
            enable_in     = 1'b0;
            pc_in         = 24'($urandom);
            instr_in      = 24'($urandom);
            result_in     = 24'($urandom);
            store_data_in = 24'($urandom);
            tgt_gp_in     = 4'($urandom);
            flags_in      = 4'($urandom);
        end
        #1;
        if (enable_in && stall_out) stall_cnt++;
        acc_last = enable_in & ~stall_out;
        if (acc_last) begin
            e.pc    = cur.pc;
            e.instr = {cur.opc, cur.pc[15:0]};
            e.res   = cur.exp_res;
            e.tgt   = cur.tgt;
            e.flg   = cur.flg;
            e.err   = cur.exp_err;
            sbq.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        for (int g = 0; g < v.gap; g++) begin
            cur_valid = 1'b0;
            step();
        end
        cur       = v;
        cur_valid = 1'b1;
        stall_cnt = 0;
        busy_cnt  = 0;
        n         = 0;
        do begin
            step();
            n++;
        end while (!acc_last && n < 100);
        chk("accepted", acc_last, 1);
        chk("stall_cycles", stall_cnt, v.exp_stall);
        chk("busy_cycles", busy_cnt, v.exp_stall);
        cur_valid = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = mk(OPC_R_ADD, 24'h000100, 24'h000123, 24'h0, 24'h0,
                     4'h1, 4'b1 << FLG_Z, 0, 1, 24'h000123, 1'b0, 0);
        vecs[1] = mk(OPC_R_LD, 24'h000104, 24'h000040, 24'h0, 24'hABCDEF,
                     4'h2, 4'b1 << FLG_N, 3, 0, 24'hABCDEF, 1'b0, 4);
        vecs[2] = mk(OPC_R_ST, 24'h000108, 24'h000010, 24'h5A5A5A, 24'h0,
                     4'h3, 4'b1 << FLG_C, 2, 2, 24'h000010, 1'b0, 3);
        vecs[3] = mk(OPC_R_LD, 24'h00010C, 24'h000200, 24'h0, 24'h123456,
                     4'h4, 4'b1 << FLG_V, 0, 0, 24'h123456, 1'b0, 1);
        vecs[4] = mk(OPC_R_ST, 24'h000110, 24'h000300, 24'h00FF00, 24'h0,
                     4'h5, 4'h0, 0, 0, 24'h000300, 1'b0, 1);
        vecs[5] = mk(OPC_I_LDi, 24'h000114, 24'hFF0044, 24'h0, 24'h777777,
                     4'h6, 4'hF, 1, 0, 24'h777777, 1'b0, 2);
        vecs[6] = mk(OPC_I_STi, 24'h000118, 24'h00ABCD, 24'h135790, 24'h0,
                     4'h7, 4'h3, 0, 1, 24'h00ABCD, 1'b0, 1);
        vecs[7] = mk(8'hFF, 24'h00011C, 24'hFFFFFF, 24'h0, 24'h0,
                     4'h8, 4'hC, 0, 0, 24'hFFFFFF, 1'b0, 0);
`ifdef STAGE4MA_TIMEOUT_EN
        vecs[8] = mk(OPC_R_LD, 24'h000120, 24'h000050, 24'h0, 24'h0C0FFE,
                     4'h9, 4'h1, 40, 0, 24'h000000, 1'b1, TO);
`else
        vecs[8] = mk(OPC_R_LD, 24'h000120, 24'h000050, 24'h0, 24'h0C0FFE,
                     4'h9, 4'h1, 40, 0, 24'h0C0FFE, 1'b0, 41);
`endif
        vecs[9] = mk(OPC_R_ADD, 24'h000124, 24'h000999, 24'h0, 24'h0,
                     4'hA, 4'h2, 0, 0, 24'h000999, 1'b0, 0);

        rst = 1'b1;
        enable_in = 1'b0; pc_in = '0; instr_in = '0;
        result_in = '0; store_data_in = '0;
        tgt_gp_in = '0; flags_in = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        cur = vecs[0]; cur_valid = 1'b0; acc_last = 1'b0;
        last = '{default: '0};
        bwait = 0; stall_cnt = 0; busy_cnt = 0;

        repeat (2) @(negedge clk);
        chk("rst_enable_out", enable_out, 0);
        chk("rst_stall_out", stall_out, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_bus_err", bus_err_out, 0);
        chk("rst_result_out", result_out, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the second BUSY cycle of an unanswered load
        cur = mk(OPC_R_LD, 24'h000400, 24'h000400, 24'h0, 24'h111111,
                 4'h5, 4'h0, 50, 0, 24'h111111, 1'b0, 0);
        cur_valid = 1'b1;
        busy_cnt  = 0;
        n = 0;
        while (busy_cnt < 2 && n < 20) begin
            step();
            n++;
        end
        chk("rst_reached_busy2", busy_cnt, 2);
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_stall_out", stall_out, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_enable_out", enable_out, 0);
        chk("midrst_result_out", result_out, 0);
        chk("midrst_pc_out", pc_out, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_bus_err", bus_err_out, 0);
        enable_in = 1'b0;
        cur_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        last = '{default: '0};
        acc_last = 1'b0;
        bwait = 0;

        run_vec(mk(OPC_R_ST, 24'h000204, 24'h000020, 24'h0A0B0C, 24'h0,
                   4'h6, 4'h0, 1, 0, 24'h000020, 1'b0, 2));
        run_vec(mk(OPC_R_ADD, 24'h000208, 24'h000777, 24'h0, 24'h0,
                   4'hB, 4'h4, 0, 0, 24'h000777, 1'b0, 0));

        cur_valid = 1'b0;
        step();
        step();
        chk("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
